trdb_stream_packer: RTL and testbench

//  Bit-exact packer: serialises variable-length trace packets into DATA_W-bit words.

---
 rtl/trdb_pkg.sv | 16 +
 rtl/trdb_bit_extract.sv | 24 ++
 rtl/trdb_stream_packer.sv | 174 +++++++++++++++++
 tb/tb_trdb_stream_packer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trdb_pkg.sv
// Shared constants and types for the trace packer datapath.
package trdb_pkg;

    localparam int unsigned PACKET_LEN        = 64;
    localparam int unsigned PACKET_HEADER_LEN = 7;
    localparam int unsigned PACKET_TOTAL      = PACKET_LEN + PACKET_HEADER_LEN;

    localparam logic [1:0] HDR_TAG = 2'b01;

    typedef enum logic [1:0] {
        StHdr,
        StPack,
        StFlush
    } packer_state_e;

endpackage

// File: rtl/trdb_bit_extract.sv
// Combinational window into the packet serial: DATA_W bits starting at ptr_i,
// with everything above the lowest n_i bits cleared.
module trdb_bit_extract
    import trdb_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    localparam int unsigned PtrW  = $clog2(PACKET_TOTAL + 1),
    localparam int unsigned CntW  = $clog2(DATA_W + 1)
) (
    input  logic [PACKET_TOTAL-1:0] serial_i,
    input  logic [PtrW-1:0]         ptr_i,
    input  logic [CntW-1:0]         n_i,
    output logic [DATA_W-1:0]       bits_o
);

    logic [DATA_W-1:0] mask;

    always_comb begin
        // A shift of DATA_W (n_i == 0) yields an all-zero mask.
        mask   = {DATA_W{1'b1}} >> (CntW'(DATA_W) - n_i);
        bits_o = DATA_W'(serial_i >> ptr_i) & mask;
    end

endmodule

// File: rtl/trdb_stream_packer.sv
// Packs variable-length trace packets back to back into DATA_W-bit words,
// with a source-ID header after reset and after every flush.
module trdb_stream_packer
    import trdb_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 5,
    parameter int unsigned ID     = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [PACKET_LEN-1:0]        packet_bits_i,
    input  logic [PACKET_HEADER_LEN-1:0] packet_len_i,
    input  logic                         valid_i,
    output logic                         grant_o,
    input  logic                         flush_i,
    output logic                         flush_done_o,
    output logic [DATA_W-1:0]            data_o,
    output logic                         valid_o,
    input  logic                         ready_i
);

    localparam int unsigned PtrW = $clog2(PACKET_TOTAL + 1);
    localparam int unsigned CntW = $clog2(DATA_W + 1);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    localparam logic [DATA_W-1:0] HdrWord = DATA_W'({ID_W'(ID), HDR_TAG});

    packer_state_e state_q, state_d;
    cnt_t              fill_q, fill_d;
    ptr_t              ptr_q, ptr_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              flush_done_q, flush_done_d;
    logic              flush_pend_q, flush_pend_d;

    logic                         adv;
    logic                         grant;
    logic [PACKET_HEADER_LEN-1:0] len_sat;
    logic [PACKET_LEN-1:0]        payload_mask;
    logic [PACKET_TOTAL-1:0]      serial;
    ptr_t                         pkt_l;
    ptr_t                         room;
    ptr_t                         left;
    ptr_t                         take;
    cnt_t                         n;
    logic [DATA_W-1:0]            chunk;
    logic [DATA_W-1:0]            acc_next;
    cnt_t                         fill_next;

    assign adv = !valid_q || ready_i;

    // Serial form of the head packet, with bits above the length cleared.
    always_comb begin
        len_sat = (packet_len_i > PACKET_HEADER_LEN'(PACKET_LEN)) ?
                  PACKET_HEADER_LEN'(PACKET_LEN) : packet_len_i;
        payload_mask = ~({PACKET_LEN{1'b1}} << len_sat);
        serial       = {packet_bits_i & payload_mask, len_sat};
        pkt_l        = ptr_t'(len_sat) + ptr_t'(PACKET_HEADER_LEN);
        room         = ptr_t'(DATA_W) - ptr_t'(fill_q);
        left         = pkt_l - ptr_q;
        take         = (room < left) ? room : left;
        n            = cnt_t'(take);
    end

    trdb_bit_extract #(
        .DATA_W (DATA_W)
    ) u_bit_extract (
        .serial_i (serial),
        .ptr_i    (ptr_q),
        .n_i      (n),
        .bits_o   (chunk)
    );

    assign acc_next  = acc_q | (chunk << fill_q);
    assign fill_next = fill_q + n;

    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        ptr_d        = ptr_q;
        acc_d        = acc_q;
        data_d       = data_q;
        valid_d      = valid_q;
        flush_done_d = 1'b0;
        flush_pend_d = flush_pend_q;
        grant        = 1'b0;

        unique case (state_q)
            StHdr: begin
                if (adv) begin
                    data_d  = HdrWord;
                    valid_d = 1'b1;
                    state_d = StPack;
                end
            end
            StPack: begin
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (adv) begin
                    valid_d = 1'b0;
                end
                // Only leave for a flush on a packet boundary.
                if ((flush_pend_q || flush_i) && (ptr_q == '0)) begin
                    state_d      = StFlush;
                    flush_pend_d = 1'b0;
                end else if (adv && valid_i) begin
                    if (fill_next == cnt_t'(DATA_W)) begin
                        data_d  = acc_next;
                        valid_d = 1'b1;
                        acc_d   = '0;
                        fill_d  = '0;
                    end else begin
                        acc_d  = acc_next;
                        fill_d = fill_next;
                    end
                    if ((ptr_q + take) == pkt_l) begin
                        grant = 1'b1;
                        ptr_d = '0;
                    end else begin
                        ptr_d = ptr_q + take;
                    end
                end
            end
            StFlush: begin
                if (adv) begin
                    if (fill_q != '0) begin
                        data_d  = acc_q;
                        valid_d = 1'b1;
                        acc_d   = '0;
                        fill_d  = '0;
                    end else begin
                        valid_d      = 1'b0;
                        flush_done_d = 1'b1;
                        state_d      = StHdr;
                    end
                end
            end
            default: state_d = StHdr;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StHdr;
            fill_q       <= '0;
            ptr_q        <= '0;
            acc_q        <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            flush_done_q <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            ptr_q        <= ptr_d;
            acc_q        <= acc_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            flush_done_q <= flush_done_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign grant_o      = grant;
    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign flush_done_o = flush_done_q;

endmodule

// File: tb/tb_trdb_stream_packer.sv
// Randomised scoreboard bench for trdb_stream_packer against a bit-queue model.
module tb_trdb_stream_packer;
    import trdb_pkg::*;

    localparam int unsigned DW  = 32;
    localparam int unsigned IDW = 5;
    localparam int unsigned IDV = 3;
    localparam logic [DW-1:0] HDR = 32'h0000_000D;

    logic                         clk_i = 1'b0;
    logic                         rst_ni;
    logic [PACKET_LEN-1:0]        packet_bits_i;
    logic [PACKET_HEADER_LEN-1:0] packet_len_i;
    logic                         valid_i;
    logic                         grant_o;
    logic                         flush_i;
    logic                         flush_done_o;
    logic [DW-1:0]                data_o;
    logic                         valid_o;
    logic                         ready_i;

    int checks = 0;
    int failures = 0;
    int ready_mode = 0;
    int flush_issued = 0;
    int flush_seen = 0;

    logic [DW-1:0] exp_q[$];
    bit            bitq[$];

    trdb_stream_packer #(
        .DATA_W (DW),
        .ID_W   (IDW),
        .ID     (IDV)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .packet_bits_i (packet_bits_i),
        .packet_len_i  (packet_len_i),
        .valid_i       (valid_i),
        .grant_o       (grant_o),
        .flush_i       (flush_i),
        .flush_done_o  (flush_done_o),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Reference model: the stream is a plain queue of bits; every DW bits is a word.
    function automatic logic [DW-1:0] pop_word();
        logic [DW-1:0] w;
        w = '0;
        for (int j = 0; j < DW; j++) begin
            if (bitq.size() > 0) w[j] = bitq.pop_front();
        end
        return w;
    endfunction

    function automatic void model_header();
        exp_q.push_back(HDR);
    endfunction

    function automatic void model_pkt(input logic [PACKET_HEADER_LEN-1:0] len,
                                      input logic [PACKET_LEN-1:0] bits);
        int unsigned lsat;
        logic [PACKET_HEADER_LEN-1:0] lf;
        lsat = (int'(len) > PACKET_LEN) ? PACKET_LEN : int'(len);
        lf = PACKET_HEADER_LEN'(lsat);
        for (int i = 0; i < PACKET_HEADER_LEN; i++) bitq.push_back(lf[i]);
        for (int i = 0; i < int'(lsat); i++) bitq.push_back(bits[i]);
        while (bitq.size() >= DW) exp_q.push_back(pop_word());
    endfunction

    function automatic void model_flush();
        if (bitq.size() > 0) exp_q.push_back(pop_word());
        bitq.delete();
        model_header();
    endfunction

    task automatic issue_pkt(input logic [PACKET_HEADER_LEN-1:0] len,
                             input logic [PACKET_LEN-1:0] bits);
        packet_len_i  = len;
        packet_bits_i = bits;
        valid_i       = 1'b1;
        model_pkt(len, bits);
    endtask

    task automatic wait_grant(input bit expect_first);
        int cyc;
        bit got;
        cyc = 0;
        got = 1'b0;
        while (cyc < 400 && !got) begin
            @(negedge clk_i);
            if (grant_o) got = 1'b1;
            else cyc++;
        end
        check("grant_seen", 64'(got), 64'd1);
        if (expect_first) check("grant_first_cycle", 64'(cyc), 64'd0);
        @(posedge clk_i);
        #1 valid_i = 1'b0;
    endtask

    task automatic do_flush();
        int cyc;
        bit got;
        flush_i = 1'b1;
        flush_issued++;
        model_flush();
        @(posedge clk_i);
        #1 flush_i = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (cyc < 400 && !got) begin
            @(negedge clk_i);
            if (flush_done_o) got = 1'b1;
            else cyc++;
        end
        check("flush_done_seen", 64'(got), 64'd1);
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        int cyc;
        ready_mode = 0;
        cyc = 0;
        while (cyc < 1000 && exp_q.size() != 0) begin
            @(negedge clk_i);
            cyc++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic random_phase(input int count);
        logic [PACKET_HEADER_LEN-1:0] len;
        ready_mode = 1;
        for (int k = 0; k < count; k++) begin
            if ($urandom_range(0, 9) == 0) len = PACKET_HEADER_LEN'($urandom_range(65, 127));
            else len = PACKET_HEADER_LEN'($urandom_range(0, 64));
            issue_pkt(len, rand64());
            wait_grant(1'b0);
            if ($urandom_range(0, 9) == 0) do_flush();
        end
        do_flush();
        drain();
    endtask

    // Sink backpressure driver.
    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #2;
            case (ready_mode)
                0:       ready_i = 1'b1;
                1:       ready_i = ($urandom_range(0, 9) < 7);
                default: ready_i = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted word and polices the handshake.
    initial begin
        bit            held;
        bit            prev_fd;
        logic [DW-1:0] held_data;
        held = 1'b0;
        prev_fd = 1'b0;
        held_data = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                held = 1'b0;
                prev_fd = 1'b0;
            end else begin
                if (held) begin
                    check("stall_valid_hold", 64'(valid_o), 64'd1);
                    check("stall_data_hold", 64'(data_o), 64'(held_data));
                end
                if (valid_o && !ready_i) check("no_grant_when_stalled", 64'(grant_o), 64'd0);
                if (!valid_i) check("grant_idle", 64'(grant_o), 64'd0);
                if (valid_o && ready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_word: got %0h expected none", data_o);
                    end else begin
                        check("word", 64'(data_o), 64'(exp_q.pop_front()));
                    end
                end
                if (flush_done_o) begin
                    flush_seen++;
                    check("flush_done_single", 64'(prev_fd), 64'd0);
                end
                prev_fd = flush_done_o;
                held = valid_o && !ready_i;
                held_data = data_o;
            end
        end
    end

    initial begin
        rst_ni        = 1'b0;
        valid_i       = 1'b0;
        flush_i       = 1'b0;
        packet_bits_i = '0;
        packet_len_i  = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_valid_o", 64'(valid_o), 64'd0);
        check("rst_data_o", 64'(data_o), 64'd0);
        check("rst_grant_o", 64'(grant_o), 64'd0);
        check("rst_flush_done_o", 64'(flush_done_o), 64'd0);
        model_header();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("hdr_valid", 64'(valid_o), 64'd1);
        check("hdr_data", 64'(data_o), 64'(HDR));
        @(posedge clk_i);
        #1;
        check("hdr_one_cycle", 64'(valid_o), 64'd0);

        // Exactly one word of packet: word and grant together.
        issue_pkt(7'd25, rand64());
        wait_grant(1'b1);
        check("full_word_valid", 64'(valid_o), 64'd1);

        // Single 20-bit packet then flush: zero-padded residual, then header.
        issue_pkt(7'd13, rand64());
        wait_grant(1'b0);
        do_flush();

        // Two 20-bit packets share one word; 8 bits carried then flushed.
        issue_pkt(7'd13, rand64());
        wait_grant(1'b0);
        issue_pkt(7'd13, rand64());
        wait_grant(1'b0);
        do_flush();

        // Sink stalls mid multi-word packet.
        issue_pkt(7'd64, rand64());
        @(posedge clk_i);
        #1 ready_mode = 2;
        repeat (6) @(posedge clk_i);
        #1 ready_mode = 0;
        wait_grant(1'b0);
        do_flush();
        drain();

        random_phase(150);

        // Reset in the middle of a multi-word packet.
        issue_pkt(7'd64, rand64());
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_ni = 1'b0;
        #1;
        check("midrst_valid_o", 64'(valid_o), 64'd0);
        check("midrst_data_o", 64'(data_o), 64'd0);
        check("midrst_grant_o", 64'(grant_o), 64'd0);
        check("midrst_flush_done_o", 64'(flush_done_o), 64'd0);
        valid_i = 1'b0;
        bitq.delete();
        exp_q.delete();
        model_header();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("post_rst_hdr_valid", 64'(valid_o), 64'd1);
        check("post_rst_hdr_data", 64'(data_o), 64'(HDR));

        random_phase(30);

        check("flush_done_count", 64'(flush_seen), 64'(flush_issued));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
